// File: rtl/cpu_plic.sv
// Platform interrupt controller feeding the CSR external-interrupt input, with a claim/complete register window.
// Optional macro CPU_PLIC_LEVEL_TRIGGER_EN makes sources level-sensitive instead of rising-edge latched.
module cpu_plic #(
    parameter int SOURCES = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [SOURCES-1:0] i_sources,
    output logic               o_interrupt,
    input  logic               i_interrupt_enable,
    input  logic               i_request,
    input  logic               i_rw,
    input  logic [3:0]         i_address,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_ready,
    output logic [5:0]         o_claimed
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t             state, state_next;
    logic               access;
    logic [SOURCES-1:0] sync_p0, sync_p1;
    logic [SOURCES-1:0] pending, enable, active;
    logic [SOURCES-1:0] claim_onehot;
    logic [5:0]         in_service, claim_id;
    logic [1:0]         reg_sel;
    logic [31:0]        rd_value;
    logic               claim_read, enable_write, complete_write;
    logic               unused_bits;

    assign reg_sel = i_address[3:2];
    assign active  = pending & enable;

    // Bus handshake: one access per request, ACK holds until the request drops
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (i_request) begin
                    access     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!i_request) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lowest-index enabled pending source wins; nothing is offered while a claim is open
    always_comb begin
        claim_id     = 6'd0;
        claim_onehot = '0;
        for (int k = SOURCES - 1; k >= 0; k--) begin
            if (active[k]) begin
                claim_id     = 6'(k + 1);
                claim_onehot = '0;
                claim_onehot[k] = 1'b1;
            end
        end
        if (in_service != 6'd0) begin
            claim_id     = 6'd0;
            claim_onehot = '0;
        end
    end

    assign claim_read     = access && !i_rw && (reg_sel == 2'd2) && (claim_id != 6'd0);
    assign enable_write   = access && i_rw && (reg_sel == 2'd1);
    assign complete_write = access && i_rw && (reg_sel == 2'd2) && (i_wdata[5:0] == in_service);

    always_comb begin
        rd_value = '0;
        case (reg_sel)
            2'd0: rd_value = 32'(pending);
            2'd1: rd_value = 32'(enable);
            2'd2: rd_value = 32'(claim_id);
            2'd3: rd_value = {18'd0, in_service, 7'd0, o_interrupt};
            default: rd_value = '0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_ready <= 1'b0;
            o_rdata <= '0;
        end else begin
            o_ready <= access;
            if (access) begin
                o_rdata <= i_rw ? 32'd0 : rd_value;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= i_sources;
            sync_p1 <= sync_p0;
        end
    end

`ifdef CPU_PLIC_LEVEL_TRIGGER_EN
    // Level mode: pending follows the synchronised line, claims never clear it
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pending <= '0;
        end else begin
            pending <= sync_p1;
        end
    end

    assign unused_bits = ^{i_wdata, i_address[1:0], claim_onehot};
`else
    logic [SOURCES-1:0] dly_p2;
    logic [SOURCES-1:0] rise;

    assign rise = sync_p1 & ~dly_p2;

    // A fresh edge outranks the claim clearing the same bit
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            dly_p2  <= '0;
            pending <= '0;
        end else begin
            dly_p2  <= sync_p1;
            pending <= (pending & ~(claim_read ? claim_onehot : '0)) | rise;
        end
    end

    assign unused_bits = ^{i_wdata, i_address[1:0]};
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            enable      <= '0;
            in_service  <= 6'd0;
            o_interrupt <= 1'b0;
        end else begin
            if (enable_write) begin
                enable <= i_wdata[SOURCES-1:0];
            end
            if (claim_read) begin
                in_service <= claim_id;
            end else if (complete_write) begin
                in_service <= 6'd0;
            end
            o_interrupt <= (|active) && (in_service == 6'd0) && i_interrupt_enable;
        end
    end

    assign o_claimed = in_service;

endmodule

// File: tb/tb_cpu_plic.sv
// Directed self-checking bench for cpu_plic in its default rising-edge configuration.
module tb_cpu_plic;

    localparam int SOURCES = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [SOURCES-1:0] src = '0;
    logic               irq;
    logic               ie = 1'b0;
    logic               req = 1'b0;
    logic               rw = 1'b0;
    logic [3:0]         addr = '0;
    logic [31:0]        wdata = '0;
    logic [31:0]        rdata;
    logic               ready;
    logic [5:0]         claimed;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_plic #(.SOURCES(SOURCES)) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_sources(src),
        .o_interrupt(irq),
        .i_interrupt_enable(ie),
        .i_request(req),
        .i_rw(rw),
        .i_address(addr),
        .i_wdata(wdata),
        .o_rdata(rdata),
        .o_ready(ready),
        .o_claimed(claimed)
    );

    // Starts on a falling edge, returns two falling edges after the acknowledge.
    task automatic bus(input logic w, input logic [1:0] reg_i, input logic [31:0] wd,
                       output logic [31:0] rd, output int pulses);
        int waited;
        pulses = 0;
        rd     = '0;
        rw     = w;
        addr   = {reg_i, 2'b00};
        wdata  = wd;
        req    = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ready && waited < 20);
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL bus_timeout ready=%b required=1", ready);
        end else begin
            pulses = 1;
            rd = rdata;
        end
        req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ready) pulses++;
        end
    endtask

    task automatic pulse(input logic [SOURCES-1:0] mask);
        src = mask;
        @(negedge clk);
        src = '0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int p;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        checks++; if (claimed !== 6'd0) begin failures++; $display("FAIL rst_claimed got=%0d exp=0", claimed); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            bus(1'b0, 2'(r), 32'd0, rd, p);
            checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rst_read%0d got=%h exp=0", r, rd); end
            checks++; if (p !== 1) begin failures++; $display("FAIL rst_pulses%0d got=%0d exp=1", r, p); end
        end
    endtask

    task automatic test_edge();
        logic [31:0] rd;
        int p;
        ie = 1'b1;
        bus(1'b1, 2'd1, 32'h04, rd, p);
        pulse(8'h04);
        @(negedge clk);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_early got=%b exp=0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq_rise got=%b exp=1", irq); end
        bus(1'b0, 2'd0, 32'd0, rd, p);
        checks++; if (rd !== 32'h04) begin failures++; $display("FAIL edge_pending got=%h exp=04", rd); end
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd3) begin failures++; $display("FAIL edge_claim got=%0d exp=3", rd); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_drop got=%b exp=0", irq); end
        checks++; if (claimed !== 6'd3) begin failures++; $display("FAIL edge_claimed got=%0d exp=3", claimed); end
        bus(1'b0, 2'd0, 32'd0, rd, p);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL edge_pending_clr got=%h exp=00", rd); end
        bus(1'b1, 2'd2, 32'd3, rd, p);
        checks++; if (claimed !== 6'd0) begin failures++; $display("FAIL edge_complete got=%0d exp=0", claimed); end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        int p;
        bus(1'b1, 2'd1, 32'hFF, rd, p);
        pulse(8'h22);
        repeat (4) @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL prio_irq got=%b exp=1", irq); end
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd2) begin failures++; $display("FAIL prio_claim1 got=%0d exp=2", rd); end
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL prio_claim2 got=%0d exp=0", rd); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL prio_irq_busy got=%b exp=0", irq); end
        bus(1'b1, 2'd2, 32'd2, rd, p);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL prio_irq_again got=%b exp=1", irq); end
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd6) begin failures++; $display("FAIL prio_claim3 got=%0d exp=6", rd); end
        bus(1'b1, 2'd2, 32'd6, rd, p);
        checks++; if (claimed !== 6'd0) begin failures++; $display("FAIL prio_done got=%0d exp=0", claimed); end
    endtask

    task automatic test_wrong_complete();
        logic [31:0] rd;
        int p;
        pulse(8'h04);
        repeat (4) @(negedge clk);
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd3) begin failures++; $display("FAIL wrong_claim got=%0d exp=3", rd); end
        bus(1'b1, 2'd2, 32'd4, rd, p);
        checks++; if (claimed !== 6'd3) begin failures++; $display("FAIL wrong_kept got=%0d exp=3", claimed); end
        bus(1'b0, 2'd3, 32'd0, rd, p);
        checks++; if (rd !== 32'h300) begin failures++; $display("FAIL wrong_status got=%h exp=300", rd); end
        bus(1'b1, 2'd2, 32'd3, rd, p);
        checks++; if (claimed !== 6'd0) begin failures++; $display("FAIL wrong_cleared got=%0d exp=0", claimed); end
        bus(1'b0, 2'd3, 32'd0, rd, p);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wrong_status0 got=%h exp=0", rd); end
    endtask

    task automatic test_gating();
        logic [31:0] rd;
        int p;
        ie = 1'b0;
        pulse(8'h01);
        repeat (6) @(negedge clk);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL gate_off got=%b exp=0", irq); end
        ie = 1'b1;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL gate_on got=%b exp=1", irq); end
        bus(1'b0, 2'd3, 32'd0, rd, p);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL gate_status got=%h exp=1", rd); end
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL gate_claim got=%0d exp=1", rd); end
        bus(1'b1, 2'd2, 32'd1, rd, p);
    endtask

    task automatic test_disabled();
        logic [31:0] rd;
        int p;
        bus(1'b1, 2'd1, 32'h00, rd, p);
        pulse(8'h08);
        repeat (5) @(negedge clk);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL dis_irq got=%b exp=0", irq); end
        bus(1'b0, 2'd0, 32'd0, rd, p);
        checks++; if (rd !== 32'h08) begin failures++; $display("FAIL dis_pending got=%h exp=08", rd); end
        bus(1'b1, 2'd1, 32'h08, rd, p);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL dis_enable_irq got=%b exp=1", irq); end
        bus(1'b1, 2'd0, 32'h00, rd, p);
        bus(1'b0, 2'd0, 32'd0, rd, p);
        checks++; if (rd !== 32'h08) begin failures++; $display("FAIL dis_pending_ro got=%h exp=08", rd); end
        bus(1'b1, 2'd1, 32'hFFFF_FFFF, rd, p);
        bus(1'b0, 2'd1, 32'd0, rd, p);
        checks++; if (rd !== 32'hFF) begin failures++; $display("FAIL dis_enable_trunc got=%h exp=ff", rd); end
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd4) begin failures++; $display("FAIL dis_claim got=%0d exp=4", rd); end
        bus(1'b1, 2'd2, 32'd4, rd, p);
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd;
        int p;
        pulse(8'h04);
        repeat (4) @(negedge clk);
        src = 8'h04;
        @(negedge clk);
        src = '0;
        @(negedge clk);
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd3) begin failures++; $display("FAIL sim_claim got=%0d exp=3", rd); end
        bus(1'b0, 2'd0, 32'd0, rd, p);
        checks++; if (rd !== 32'h04) begin failures++; $display("FAIL sim_set_wins got=%h exp=04", rd); end
        src = 8'h40;
        @(negedge clk);
        src = '0;
        @(negedge clk);
        bus(1'b1, 2'd2, 32'd3, rd, p);
        checks++; if (claimed !== 6'd0) begin failures++; $display("FAIL sim_complete got=%0d exp=0", claimed); end
        bus(1'b0, 2'd0, 32'd0, rd, p);
        checks++; if (rd !== 32'h44) begin failures++; $display("FAIL sim_both got=%h exp=44", rd); end
        bus(1'b0, 2'd2, 32'd0, rd, p);
        bus(1'b1, 2'd2, 32'd3, rd, p);
        bus(1'b0, 2'd2, 32'd0, rd, p);
        checks++; if (rd !== 32'd7) begin failures++; $display("FAIL sim_claim7 got=%0d exp=7", rd); end
        bus(1'b1, 2'd2, 32'd7, rd, p);
        bus(1'b0, 2'd0, 32'd0, rd, p);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL sim_empty got=%h exp=00", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [31:0] held_rd;
        int p;
        int held;
        pulse(8'h01);
        repeat (4) @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rmid_irq got=%b exp=1", irq); end
        rw   = 1'b0;
        addr = 4'h0;
        req  = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rmid_ack got=%b exp=1", ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%b exp=0", ready); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rmid_irq0 got=%b exp=0", irq); end
        @(negedge clk);
        rst_n = 1'b1;
        held = 0;
        held_rd = 32'hDEAD_BEEF;
        repeat (6) begin
            @(negedge clk);
            if (ready) begin
                held++;
                held_rd = rdata;
            end
        end
        req = 1'b0;
        checks++; if (held !== 1) begin failures++; $display("FAIL rmid_once got=%0d exp=1", held); end
        checks++; if (held_rd !== 32'h0) begin failures++; $display("FAIL rmid_pending got=%h exp=0", held_rd); end
        repeat (2) @(negedge clk);
        bus(1'b0, 2'd1, 32'd0, rd, p);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_enable got=%h exp=0", rd); end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_priority();
        test_wrong_complete();
        test_gating();
        test_disabled();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
